// File: rtl/patch_table_pkg.sv
// Shared definitions for the address-triggered patch table: config register
// offsets, the AHI enable bit and the per-entry record.
package patch_table_pkg;

    localparam int PT_DATA_AW = 10;
    localparam int PT_ADDR_W  = 23;

    localparam logic [2:0] PT_SEL   = 3'd0;
    localparam logic [2:0] PT_ALO   = 3'd1;
    localparam logic [2:0] PT_AHI   = 3'd2;
    localparam logic [2:0] PT_OFS   = 3'd3;
    localparam logic [2:0] PT_WPTR  = 3'd4;
    localparam logic [2:0] PT_WDATA = 3'd5;

    localparam int AHI_ENABLE_BIT = 15;

    typedef struct packed {
        logic                  enable;
        logic [PT_ADDR_W-1:0]  address;
        logic [PT_DATA_AW-1:0] offset;
    } pt_entry_t;

endpackage

// File: rtl/patch_table_data_ram.sv
// Patch-data RAM: one config write port and one registered read port.
// A same-address write and read in one cycle returns the old word.
module patch_data_ram #(
    parameter int AW = 10
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [15:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [15:0]   o_rdata
);

    logic [15:0] r_mem [2**AW];
    logic [15:0] r_rdata;

    always_ff @(posedge i_clk) begin
        r_rdata <= r_mem[i_raddr];
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/patch_table.sv
// Address-triggered read patch table: config-loaded entries are matched
// against latched RAM addresses and the matching patch words are played back.
module patch_table
    import patch_table_pkg::*;
#(
    parameter int          NUM_PATCHES = 8,
    parameter int          DATA_AW     = PT_DATA_AW,
    parameter logic [15:0] CFG_BASE    = 16'h0100
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic [15:0] config_addr,
    input  logic [15:0] config_data,
    input  logic        config_strobe,
    input  logic [22:0] addr,
    input  logic        addr_strobe,
    output logic        trigger,
    output logic [15:0] data,
    input  logic        data_next
);

    localparam int SEL_W = $clog2(NUM_PATCHES);

    pt_entry_t              r_entry [NUM_PATCHES];
    logic [SEL_W-1:0]       r_sel;
    logic [DATA_AW-1:0]     r_wptr;
    logic [NUM_PATCHES-1:0] r_match;
    logic [DATA_AW-1:0]     r_win_ofs;
    logic                   r_hit_pending;
    logic                   r_trigger;
    logic [15:0]            r_data;
    logic [DATA_AW-1:0]     r_rptr;

    logic [15:0]            w_cfg_off;
    logic                   w_cfg_hit;
    logic                   w_ram_we;
    logic [NUM_PATCHES-1:0] w_match;
    logic [DATA_AW-1:0]     w_win_ofs;
    logic                   w_load;
    logic                   w_adv;
    logic [DATA_AW-1:0]     w_rd_addr;
    logic [15:0]            w_ram_q;

    assign w_cfg_off = config_addr - CFG_BASE;
    assign w_cfg_hit = config_strobe && (config_addr >= CFG_BASE) && (w_cfg_off < 16'd6);
    assign w_ram_we  = w_cfg_hit && (w_cfg_off[2:0] == PT_WDATA);

    // Descending scan so the lowest-index match wins.
    always_comb begin
        w_match   = '0;
        w_win_ofs = '0;
        for (int i = 0; i < NUM_PATCHES; i++) begin
            w_match[i] = r_entry[i].enable && (r_entry[i].address == addr);
        end
        for (int i = NUM_PATCHES - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_win_ofs = r_entry[i].offset;
            end
        end
    end

    // The read port always tracks the word that the next advance will present.
    assign w_load    = |r_match;
    assign w_adv     = !w_load && (r_hit_pending || data_next);
    assign w_rd_addr = w_load ? r_win_ofs : (w_adv ? r_rptr + 1'b1 : r_rptr);

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PATCHES; i++) begin
                r_entry[i] <= '0;
            end
            r_sel  <= '0;
            r_wptr <= '0;
        end else if (w_cfg_hit) begin
            case (w_cfg_off[2:0])
                PT_SEL:   r_sel <= config_data[SEL_W-1:0];
                PT_ALO:   r_entry[r_sel].address[15:0] <= config_data;
                PT_AHI: begin
                    r_entry[r_sel].address[22:16] <= config_data[6:0];
                    r_entry[r_sel].enable         <= config_data[AHI_ENABLE_BIT];
                end
                PT_OFS:   r_entry[r_sel].offset <= config_data[DATA_AW-1:0];
                PT_WPTR:  r_wptr <= config_data[DATA_AW-1:0];
                PT_WDATA: r_wptr <= r_wptr + 1'b1;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_match       <= '0;
            r_win_ofs     <= '0;
            r_hit_pending <= 1'b0;
            r_trigger     <= 1'b0;
            r_data        <= 16'h0000;
            r_rptr        <= '0;
        end else begin
            // Snapshot the winner's offset so later config writes cannot disturb it.
            r_match <= addr_strobe ? w_match : '0;
            if (addr_strobe) begin
                r_win_ofs <= w_win_ofs;
            end
            r_hit_pending <= w_load;
            r_trigger     <= r_hit_pending;
            if (w_load) begin
                r_rptr <= r_win_ofs;
            end else if (w_adv) begin
                r_data <= w_ram_q;
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    patch_data_ram #(
        .AW(DATA_AW)
    ) u_ram (
        .i_clk   (mclk),
        .i_we    (w_ram_we),
        .i_waddr (r_wptr),
        .i_wdata (config_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_ram_q)
    );

    assign trigger = r_trigger;
    assign data    = r_data;

endmodule

// File: tb/tb_patch_table.sv
// Directed bench for patch_table: match, enable/partial match, priority,
// wrap, restart with discarded data_next, and reset during playback.
module tb_patch_table;

    localparam logic [15:0] CFG_BASE = 16'h0100;

    logic        mclk;
    logic        reset;
    logic [15:0] config_addr;
    logic [15:0] config_data;
    logic        config_strobe;
    logic [22:0] addr;
    logic        addr_strobe;
    logic        trigger;
    logic [15:0] data;
    logic        data_next;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    patch_table #(
        .NUM_PATCHES(8),
        .DATA_AW(10),
        .CFG_BASE(CFG_BASE)
    ) dut (
        .mclk          (mclk),
        .reset         (reset),
        .config_addr   (config_addr),
        .config_data   (config_data),
        .config_strobe (config_strobe),
        .addr          (addr),
        .addr_strobe   (addr_strobe),
        .trigger       (trigger),
        .data          (data),
        .data_next     (data_next)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] off, input logic [15:0] d);
        config_addr   = CFG_BASE + {13'd0, off};
        config_data   = d;
        config_strobe = 1'b1;
        tick();
        config_strobe = 1'b0;
    endtask

    task automatic load_entry(input logic [2:0] idx, input logic [22:0] a,
                              input logic en, input logic [9:0] ofs);
        cfg_write(3'd0, {13'd0, idx});
        cfg_write(3'd1, a[15:0]);
        cfg_write(3'd2, {en, 8'd0, a[22:16]});
        cfg_write(3'd3, {6'd0, ofs});
    endtask

    // Strobe an address; trigger must pulse exactly two edges later (or never).
    task automatic strobe(input string tag, input logic [22:0] a,
                          input logic exp_trig, input logic [15:0] exp_data);
        addr        = a;
        addr_strobe = 1'b1;
        tick();
        addr_strobe = 1'b0;
        check({tag, "_trig_c1"}, {31'd0, trigger}, 32'd0);
        tick();
        check({tag, "_trig_c2"}, {31'd0, trigger}, 32'd0);
        tick();
        check({tag, "_trig"}, {31'd0, trigger}, {31'd0, exp_trig});
        check({tag, "_data"}, {16'd0, data}, {16'd0, exp_data});
        tick();
        check({tag, "_trig_end"}, {31'd0, trigger}, 32'd0);
    endtask

    task automatic play(input string tag, input int n);
        logic [15:0] e;
        for (int i = 0; i < n; i++) begin
            data_next = 1'b1;
            tick();
            data_next = 1'b0;
            e = exp_q.pop_front();
            check({tag, "_next"}, {16'd0, data}, {16'd0, e});
        end
    endtask

    initial begin
        reset         = 1'b1;
        config_addr   = 16'h0000;
        config_data   = 16'h0000;
        config_strobe = 1'b0;
        addr          = 23'd0;
        addr_strobe   = 1'b0;
        data_next     = 1'b0;
        tick();
        tick();
        check("reset_trig", {31'd0, trigger}, 32'd0);
        check("reset_data", {16'd0, data}, 32'd0);
        reset = 1'b0;
        tick();

        cfg_write(3'd4, 16'd0);
        cfg_write(3'd5, 16'h1111);
        cfg_write(3'd5, 16'h2222);
        cfg_write(3'd5, 16'h3333);
        cfg_write(3'd5, 16'h4444);
        cfg_write(3'd4, 16'd8);
        cfg_write(3'd5, 16'h8888);
        cfg_write(3'd5, 16'h9999);
        cfg_write(3'd4, 16'd16);
        cfg_write(3'd5, 16'h1616);
        cfg_write(3'd4, 16'd32);
        cfg_write(3'd5, 16'h3232);

        // Basic match and playback
        load_entry(3'd0, 23'h012345, 1'b1, 10'd0);
        strobe("match", 23'h012345, 1'b1, 16'h1111);
        exp_q.push_back(16'h2222);
        exp_q.push_back(16'h3333);
        exp_q.push_back(16'h4444);
        play("match", 3);

        // Disabled entry, then partial address match
        load_entry(3'd1, 23'h400000, 1'b0, 10'd8);
        strobe("disabled", 23'h400000, 1'b0, 16'h4444);
        cfg_write(3'd2, 16'h8040);
        strobe("partial", 23'h400001, 1'b0, 16'h4444);
        strobe("enabled", 23'h400000, 1'b1, 16'h8888);
        exp_q.push_back(16'h9999);
        play("enabled", 1);

        // Lowest index wins
        load_entry(3'd2, 23'h000100, 1'b1, 10'd16);
        load_entry(3'd5, 23'h000100, 1'b1, 10'd32);
        strobe("priority", 23'h000100, 1'b1, 16'h1616);

        // Offset wrap; wptr auto-increment also wraps 1023 -> 0
        cfg_write(3'd4, 16'd1023);
        cfg_write(3'd5, 16'hABCD);
        cfg_write(3'd5, 16'h0F0F);
        load_entry(3'd3, 23'h7FFFFF, 1'b1, 10'd1023);
        strobe("wrap", 23'h7FFFFF, 1'b1, 16'hABCD);
        exp_q.push_back(16'h0F0F);
        play("wrap", 1);

        // Restart during playback; data_next in the load cycle is discarded,
        // data_next during trigger is applied after the load.
        strobe("restart_a", 23'h012345, 1'b1, 16'h0F0F);
        exp_q.push_back(16'h2222);
        play("restart_a", 1);
        addr        = 23'h400000;
        addr_strobe = 1'b1;
        tick();
        addr_strobe = 1'b0;
        data_next   = 1'b1;
        tick();
        data_next   = 1'b0;
        check("restart_c1_trig", {31'd0, trigger}, 32'd0);
        check("restart_c1_data", {16'd0, data}, 32'h2222);
        tick();
        check("restart_trig", {31'd0, trigger}, 32'd1);
        check("restart_data", {16'd0, data}, 32'h8888);
        data_next = 1'b1;
        tick();
        data_next = 1'b0;
        check("restart_trig_end", {31'd0, trigger}, 32'd0);
        check("restart_next_on_trig", {16'd0, data}, 32'h9999);

        // Reset mid-playback clears outputs at once and wipes the entries
        strobe("prereset", 23'h012345, 1'b1, 16'h0F0F);
        exp_q.push_back(16'h2222);
        play("prereset", 1);
        reset = 1'b1;
        #2;
        check("midreset_trig", {31'd0, trigger}, 32'd0);
        check("midreset_data", {16'd0, data}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        strobe("postreset", 23'h012345, 1'b0, 16'h0000);

        check("exp_q_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
